// File: rtl/data_sram_responder_if.sv
// Data SRAM port bundle between the core's execute/memory stages
// and the data-side responder.
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side memory responder: byte-writable RAM plus an MMIO window
// holding a timer, compare/interrupt logic and a scratch register.
module data_sram_responder #(
    parameter int          MEM_AW    = 14,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    data_sram_responder_if.slave        bus,
    output logic [7:0]                  hardware_interrupt_data
);

    logic [31:0]       mem [2**MEM_AW];

    logic              en;
    logic [3:0]        we;
    logic [31:0]       addr;
    logic [31:0]       wdata;

    logic              is_mmio;
    logic [MEM_AW-1:0] word_idx;
    logic [13:0]       reg_sel;
    logic [31:0]       mask;
    logic              mmio_wr;

    logic              sel_timer;
    logic              sel_cmp;
    logic              sel_ctrl;
    logic              sel_status;
    logic              sel_scratch;

    logic [31:0]       timer;
    logic [31:0]       compare;
    logic [1:0]        ctrl;
    logic              pending;
    logic [31:0]       scratch;
    logic [31:0]       rdata_q;
    logic [31:0]       mmio_rd;

    logic              match;
    logic              status_clr;
    logic              unused_addr;

    assign en    = bus.data_sram_en;
    assign we    = bus.data_sram_we;
    assign addr  = bus.data_sram_addr;
    assign wdata = bus.data_sram_wdata;

    // Byte offset within a word never selects anything.
    assign unused_addr = ^addr[1:0];

    assign is_mmio  = addr[31:16] == MMIO_BASE[31:16];
    assign word_idx = addr[MEM_AW+1:2];
    assign reg_sel  = addr[15:2];
    assign mask     = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    assign mmio_wr  = en && is_mmio && (we != 4'b0000);

    assign sel_timer   = reg_sel == 14'd0;
    assign sel_cmp     = reg_sel == 14'd1;
    assign sel_ctrl    = reg_sel == 14'd2;
    assign sel_status  = reg_sel == 14'd3;
    assign sel_scratch = reg_sel == 14'd4;

    // Match uses the pre-increment timer so PENDING lands one cycle later.
    assign match      = ctrl[0] && (timer == compare);
    assign status_clr = mmio_wr && sel_status && we[0] && wdata[0];

    // MMIO read mux; unmapped offsets read as zero.
    always_comb begin
        mmio_rd = '0;
        unique case (1'b1)
            sel_timer:   mmio_rd = timer;
            sel_cmp:     mmio_rd = compare;
            sel_ctrl:    mmio_rd = {30'd0, ctrl};
            sel_status:  mmio_rd = {31'd0, pending};
            sel_scratch: mmio_rd = scratch;
            default:     mmio_rd = '0;
        endcase
    end

    // RAM byte writes; contents survive reset and reset-cycle writes drop.
    always_ff @(posedge clk) begin
        if (rst_n && en && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registers, timer/interrupt state and read-before-write rdata.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer   <= '0;
            compare <= '0;
            ctrl    <= '0;
            pending <= 1'b0;
            scratch <= '0;
            rdata_q <= '0;
        end else begin
            if (mmio_wr && sel_timer) begin
                timer <= (timer & ~mask) | (wdata & mask);
            end else if (ctrl[0]) begin
                timer <= timer + 32'd1;
            end

            if (mmio_wr && sel_cmp) begin
                compare <= (compare & ~mask) | (wdata & mask);
            end

            if (mmio_wr && sel_ctrl) begin
                ctrl <= (ctrl & ~mask[1:0]) | (wdata[1:0] & mask[1:0]);
            end

            if (mmio_wr && sel_scratch) begin
                scratch <= (scratch & ~mask) | (wdata & mask);
            end

            if (match) begin
                pending <= 1'b1;
            end else if (status_clr) begin
                pending <= 1'b0;
            end

            if (en) begin
                rdata_q <= is_mmio ? mmio_rd : mem[word_idx];
            end
        end
    end

    assign bus.data_sram_rdata     = rdata_q;
    assign hardware_interrupt_data = {7'd0, pending & ctrl[1]};

endmodule
